// File: rtl/bg_grid_draw.sv
// -----------------------------------------------------------------------------
// bg_grid_draw
// Background renderer for the VGA path, and the lowest layer of the
// object-priority mux. Every pixel is classified into one of four regions:
// blank (off-screen), outside fill, playfield border, or checkerboard floor.
// The result is registered, so the colour has one cycle of latency.
// A small FSM makes the border flash when flashTrig pulses.
//
// Ports
//   clk             in   system clock
//   resetN          in   synchronous, active-low reset
//   pixelX[10:0]    in   current pixel column
//   pixelY[10:0]    in   current pixel row
//   startOfFrame    in   one-cycle pulse at frame start
//   flashTrig       in   one-cycle pulse that starts or restarts a flash
//   BG_RGB[7:0]     out  registered RRRGGGBB background colour
//   boardersDrawReq out  registered; high when the pixel is a border pixel
//   flashActive     out  registered; high while the flash FSM is not idle
// -----------------------------------------------------------------------------
module bg_grid_draw #(
   parameter int         FRAME_W       = 640,
   parameter int         FRAME_H       = 480,
   parameter int         BORDER_OFFSET = 30,
   parameter int         BORDER_THICK  = 2,
   parameter int         TILE_LOG2     = 5,
   parameter logic [7:0] BORDER_COLOR  = 8'hFC,
   parameter logic [7:0] FLASH_COLOR   = 8'hE0,
   parameter logic [7:0] FLOOR_A       = 8'h49,
   parameter logic [7:0] FLOOR_B       = 8'h6D,
   parameter logic [7:0] OUTSIDE_COLOR = 8'hFF,
   parameter int         FLASH_PERIOD  = 4,
   parameter int         FLASH_BLINKS  = 3
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        startOfFrame,
   input  logic        flashTrig,
   output logic [7:0]  BG_RGB,
   output logic        boardersDrawReq,
   output logic        flashActive
);

   // Region limits, all 11-bit unsigned
   localparam logic [10:0] FRAME_W_L = 11'(FRAME_W);
   localparam logic [10:0] FRAME_H_L = 11'(FRAME_H);
   localparam logic [10:0] XL        = 11'(BORDER_OFFSET);
   localparam logic [10:0] XR        = 11'(FRAME_W - 1 - BORDER_OFFSET);
   localparam logic [10:0] YT        = 11'(BORDER_OFFSET);
   localparam logic [10:0] YB        = 11'(FRAME_H - 1 - BORDER_OFFSET);
   localparam logic [10:0] XL_IN     = 11'(BORDER_OFFSET + BORDER_THICK - 1);
   localparam logic [10:0] XR_IN     = 11'(FRAME_W - BORDER_OFFSET - BORDER_THICK);
   localparam logic [10:0] YT_IN     = 11'(BORDER_OFFSET + BORDER_THICK - 1);
   localparam logic [10:0] YB_IN     = 11'(FRAME_H - BORDER_OFFSET - BORDER_THICK);
   localparam logic [10:0] FLOOR_X0  = 11'(BORDER_OFFSET + BORDER_THICK);
   localparam logic [10:0] FLOOR_Y0  = 11'(BORDER_OFFSET + BORDER_THICK);

   // Only bit TILE_LOG2 of the floor offset selects the tile colour, and the
   // low bits of a difference depend only on the low bits of its operands,
   // so a (TILE_LOG2+1)-bit subtraction is enough.
   localparam logic [TILE_LOG2:0] FLOOR_X0_LO = FLOOR_X0[TILE_LOG2:0];
   localparam logic [TILE_LOG2:0] FLOOR_Y0_LO = FLOOR_Y0[TILE_LOG2:0];
   localparam logic [TILE_LOG2:0] TILE_HALF   = (TILE_LOG2 + 1)'(1) << TILE_LOG2;

   // Flash FSM encoding and counter constants
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_FLASH_ON  = 2'd1;
   localparam logic [1:0] ST_FLASH_OFF = 2'd2;

   localparam int FRAME_CW = $clog2(FLASH_PERIOD) + 1;
   localparam int BLINK_CW = $clog2(FLASH_BLINKS) + 1;
   localparam logic [FRAME_CW-1:0] FRAME_ONE  = FRAME_CW'(1);
   localparam logic [FRAME_CW-1:0] FRAME_LAST = FRAME_CW'(FLASH_PERIOD - 1);
   localparam logic [BLINK_CW-1:0] BLINK_ONE  = BLINK_CW'(1);
   localparam logic [BLINK_CW-1:0] BLINK_DONE = BLINK_CW'(FLASH_BLINKS);

   logic [1:0]          state_r;
   logic [1:0]          state_next_s;
   logic [FRAME_CW-1:0] frame_cnt_r;
   logic [FRAME_CW-1:0] frame_cnt_next_s;
   logic [BLINK_CW-1:0] blink_cnt_r;
   logic [BLINK_CW-1:0] blink_cnt_next_s;

   logic [TILE_LOG2:0]  dx_lo_s;
   logic [TILE_LOG2:0]  dy_lo_s;
   logic                tile_odd_s;
   logic [7:0]          border_color_s;
   logic [7:0]          rgb_next_s;
   logic                req_next_s;

   assign dx_lo_s    = pixelX[TILE_LOG2:0] - FLOOR_X0_LO;
   assign dy_lo_s    = pixelY[TILE_LOG2:0] - FLOOR_Y0_LO;
   assign tile_odd_s = (dx_lo_s >= TILE_HALF) ^ (dy_lo_s >= TILE_HALF);

   // Border colour follows the FSM state held before the current edge
   always_comb begin
      border_color_s = BORDER_COLOR;
      if (state_r == ST_FLASH_ON) begin
         border_color_s = FLASH_COLOR;
      end else begin
         border_color_s = BORDER_COLOR;
      end
   end

   // Region classification in priority order: blank, outside, border, floor
   always_comb begin
      rgb_next_s = 8'h00;
      req_next_s = 1'b0;
      if ((pixelX >= FRAME_W_L) || (pixelY >= FRAME_H_L)) begin
         rgb_next_s = 8'h00;
         req_next_s = 1'b0;
      end else if ((pixelX < XL) || (pixelX > XR) || (pixelY < YT) || (pixelY > YB)) begin
         rgb_next_s = OUTSIDE_COLOR;
         req_next_s = 1'b0;
      end else if ((pixelX <= XL_IN) || (pixelX >= XR_IN) ||
                   (pixelY <= YT_IN) || (pixelY >= YB_IN)) begin
         rgb_next_s = border_color_s;
         req_next_s = 1'b1;
      end else begin
         rgb_next_s = tile_odd_s ? FLOOR_B : FLOOR_A;
         req_next_s = 1'b0;
      end
   end

   // Flash FSM next state; a trigger overrides everything, including a
   // simultaneous frame pulse, which is then not counted
   always_comb begin
      state_next_s     = state_r;
      frame_cnt_next_s = frame_cnt_r;
      blink_cnt_next_s = blink_cnt_r;
      if (flashTrig) begin
         state_next_s     = ST_FLASH_ON;
         frame_cnt_next_s = '0;
         blink_cnt_next_s = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_next_s     = ST_IDLE;
               frame_cnt_next_s = '0;
               blink_cnt_next_s = '0;
            end
            ST_FLASH_ON: begin
               if (startOfFrame) begin
                  if (frame_cnt_r == FRAME_LAST) begin
                     frame_cnt_next_s = '0;
                     blink_cnt_next_s = blink_cnt_r + BLINK_ONE;
                     state_next_s     = ST_FLASH_OFF;
                  end else begin
                     frame_cnt_next_s = frame_cnt_r + FRAME_ONE;
                  end
               end else begin
                  state_next_s = ST_FLASH_ON;
               end
            end
            ST_FLASH_OFF: begin
               if (startOfFrame) begin
                  if (frame_cnt_r == FRAME_LAST) begin
                     frame_cnt_next_s = '0;
                     if (blink_cnt_r == BLINK_DONE) begin
                        // counters are parked at zero while idle
                        state_next_s     = ST_IDLE;
                        blink_cnt_next_s = '0;
                     end else begin
                        state_next_s = ST_FLASH_ON;
                     end
                  end else begin
                     frame_cnt_next_s = frame_cnt_r + FRAME_ONE;
                  end
               end else begin
                  state_next_s = ST_FLASH_OFF;
               end
            end
            default: begin
               state_next_s     = ST_IDLE;
               frame_cnt_next_s = '0;
               blink_cnt_next_s = '0;
            end
         endcase
      end
   end

   // State, counters and all outputs, with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_r         <= ST_IDLE;
         frame_cnt_r     <= '0;
         blink_cnt_r     <= '0;
         BG_RGB          <= 8'h00;
         boardersDrawReq <= 1'b0;
         flashActive     <= 1'b0;
      end else begin
         state_r         <= state_next_s;
         frame_cnt_r     <= frame_cnt_next_s;
         blink_cnt_r     <= blink_cnt_next_s;
         BG_RGB          <= rgb_next_s;
         boardersDrawReq <= req_next_s;
         flashActive     <= (state_next_s != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_bg_grid_draw.sv
// -----------------------------------------------------------------------------
// tb_bg_grid_draw
// Directed self-checking bench for bg_grid_draw with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the inputs sampled at the previous edge.
// -----------------------------------------------------------------------------
module tb_bg_grid_draw;

   logic        clk;
   logic        resetN;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        startOfFrame;
   logic        flashTrig;
   logic [7:0]  BG_RGB;
   logic        boardersDrawReq;
   logic        flashActive;

   int tests_run;
   int tests_failed;

   bg_grid_draw dut (
      .clk             (clk),
      .resetN          (resetN),
      .pixelX          (pixelX),
      .pixelY          (pixelY),
      .startOfFrame    (startOfFrame),
      .flashTrig       (flashTrig),
      .BG_RGB          (BG_RGB),
      .boardersDrawReq (boardersDrawReq),
      .flashActive     (flashActive)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pixel(input int x, input int y);
      pixelX = 11'(x);
      pixelY = 11'(y);
   endtask

   // One frame pulse, then one more edge so BG_RGB shows the new state
   task automatic frame_pulse();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
   endtask

   task automatic trigger();
      flashTrig = 1'b1;
      step();
      flashTrig = 1'b0;
      step();
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      set_pixel(100, 100);
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (BG_RGB !== 8'h00 || boardersDrawReq !== 1'b0 || flashActive !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset cyc%0d: rgb=%h req=%b act=%b, want rgb=00 req=0 act=0",
                     i, BG_RGB, boardersDrawReq, flashActive);
         end
      end
      resetN = 1'b1;
      step();
      tests_run++;
      if (BG_RGB !== 8'h49 || boardersDrawReq !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: rgb=%h req=%b, want rgb=49 req=0", BG_RGB, boardersDrawReq);
      end
   endtask

   task automatic test_regions();
      int         xs   [14] = '{30, 31, 608, 609, 100, 100, 29, 610, 32, 63, 64, 64, 32, 700};
      int         ys   [14] = '{100, 100, 100, 200, 448, 449, 100, 100, 32, 32, 32, 64, 64, 10};
      logic [7:0] rgbs [14] = '{8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFF, 8'hFF,
                                8'h49, 8'h49, 8'h6D, 8'h49, 8'h6D, 8'h00};
      logic       reqs [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 14; i++) begin
         set_pixel(xs[i], ys[i]);
         step();
         tests_run++;
         if (BG_RGB !== rgbs[i] || boardersDrawReq !== reqs[i]) begin
            tests_failed++;
            $display("FAIL region (%0d,%0d): rgb=%h req=%b, want rgb=%h req=%b",
                     xs[i], ys[i], BG_RGB, boardersDrawReq, rgbs[i], reqs[i]);
         end
      end
      // second blank pixel
      set_pixel(10, 500);
      step();
      tests_run++;
      if (BG_RGB !== 8'h00 || boardersDrawReq !== 1'b0) begin
         tests_failed++;
         $display("FAIL blank (10,500): rgb=%h req=%b, want rgb=00 req=0", BG_RGB, boardersDrawReq);
      end
   endtask

   // Checks that the registered output lags the pixel by exactly one edge
   task automatic test_latency();
      set_pixel(29, 100);
      step();
      set_pixel(32, 32);
      tests_run++;
      if (BG_RGB !== 8'hFF) begin
         tests_failed++;
         $display("FAIL latency_hold: rgb=%h, want FF", BG_RGB);
      end
      step();
      tests_run++;
      if (BG_RGB !== 8'h49) begin
         tests_failed++;
         $display("FAIL latency_update: rgb=%h, want 49", BG_RGB);
      end
   endtask

   task automatic test_flash();
      logic [7:0] want;
      set_pixel(30, 30);
      step();
      flashTrig = 1'b1;
      step();
      flashTrig = 1'b0;
      // state already FLASH_ON, but this edge still used IDLE colour
      tests_run++;
      if (BG_RGB !== 8'hFC || flashActive !== 1'b1) begin
         tests_failed++;
         $display("FAIL flash_trig_edge: rgb=%h act=%b, want rgb=FC act=1", BG_RGB, flashActive);
      end
      step();
      for (int k = 0; k < 24; k++) begin
         if (k > 0) frame_pulse();
         want = (((k / 4) % 2) == 0) ? 8'hE0 : 8'hFC;
         tests_run++;
         if (BG_RGB !== want || flashActive !== 1'b1 || boardersDrawReq !== 1'b1) begin
            tests_failed++;
            $display("FAIL flash frame%0d: rgb=%h act=%b req=%b, want rgb=%h act=1 req=1",
                     k, BG_RGB, flashActive, boardersDrawReq, want);
         end
      end
      frame_pulse();
      tests_run++;
      if (BG_RGB !== 8'hFC || flashActive !== 1'b0) begin
         tests_failed++;
         $display("FAIL flash_end: rgb=%h act=%b, want rgb=FC act=0", BG_RGB, flashActive);
      end
      frame_pulse();
      tests_run++;
      if (BG_RGB !== 8'hFC || flashActive !== 1'b0) begin
         tests_failed++;
         $display("FAIL flash_idle_stay: rgb=%h act=%b, want rgb=FC act=0", BG_RGB, flashActive);
      end
   endtask

   task automatic test_restart();
      logic [7:0] want;
      set_pixel(30, 30);
      trigger();
      for (int k = 0; k < 10; k++) frame_pulse();
      // frame 10 lies in the second ON phase
      tests_run++;
      if (BG_RGB !== 8'hE0) begin
         tests_failed++;
         $display("FAIL restart_pre: rgb=%h, want E0", BG_RGB);
      end
      flashTrig    = 1'b1;
      startOfFrame = 1'b1;
      step();
      flashTrig    = 1'b0;
      startOfFrame = 1'b0;
      step();
      for (int k = 0; k < 24; k++) begin
         if (k > 0) frame_pulse();
         want = (((k / 4) % 2) == 0) ? 8'hE0 : 8'hFC;
         tests_run++;
         if (BG_RGB !== want || flashActive !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart frame%0d: rgb=%h act=%b, want rgb=%h act=1",
                     k, BG_RGB, flashActive, want);
         end
      end
      frame_pulse();
      tests_run++;
      if (flashActive !== 1'b0 || BG_RGB !== 8'hFC) begin
         tests_failed++;
         $display("FAIL restart_end: rgb=%h act=%b, want rgb=FC act=0", BG_RGB, flashActive);
      end
   endtask

   task automatic test_reset_mid_flash();
      set_pixel(30, 30);
      trigger();
      for (int k = 0; k < 5; k++) frame_pulse();
      tests_run++;
      if (flashActive !== 1'b1 || BG_RGB !== 8'hFC) begin
         tests_failed++;
         $display("FAIL midreset_pre: rgb=%h act=%b, want rgb=FC act=1", BG_RGB, flashActive);
      end
      resetN = 1'b0;
      step();
      tests_run++;
      if (flashActive !== 1'b0 || BG_RGB !== 8'h00 || boardersDrawReq !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_hold: rgb=%h act=%b req=%b, want rgb=00 act=0 req=0",
                  BG_RGB, flashActive, boardersDrawReq);
      end
      resetN = 1'b1;
      for (int k = 0; k < 3; k++) frame_pulse();
      tests_run++;
      if (flashActive !== 1'b0 || BG_RGB !== 8'hFC) begin
         tests_failed++;
         $display("FAIL midreset_after: rgb=%h act=%b, want rgb=FC act=0", BG_RGB, flashActive);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      resetN       = 1'b0;
      pixelX       = 11'd0;
      pixelY       = 11'd0;
      startOfFrame = 1'b0;
      flashTrig    = 1'b0;
      #1;
      test_reset();
      test_regions();
      test_latency();
      test_flash();
      test_restart();
      test_reset_mid_flash();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bg_grid_draw.md
# bg_grid_draw

Parametrised background renderer for the VGA path. For each (pixelX, pixelY) it produces a registered 8-bit RRRGGGBB background colour with one cycle of latency. The picture is an outer fill colour, a rectangular playfield border of configurable offset and thickness, and a two-colour checkerboard floor inside the border. On request, the border flashes for a set number of frames under a small state machine. The output feeds the object-priority mux as the lowest layer; boardersDrawReq feeds collision logic.

## Interface
- FRAME_W, 640, visible frame width in pixels
- FRAME_H, 480, visible frame height in pixels
- BORDER_OFFSET, 30, distance from the frame edge to the outer edge of the border
- BORDER_THICK, 2, border thickness in pixels (≥1)
- TILE_LOG2, 5, log2 of the checkerboard tile edge (5 gives 32 px tiles)
- BORDER_COLOR, 8'hFC, border colour when not flashing
- FLASH_COLOR, 8'hE0, border colour during the flash ON phase
- FLOOR_A, 8'h49, colour of even tiles
- FLOOR_B, 8'h6D, colour of odd tiles
- OUTSIDE_COLOR, 8'hFF, colour between the frame edge and the border
- FLASH_PERIOD, 4, frames per ON phase and per OFF phase (≥1)
- FLASH_BLINKS, 3, number of ON/OFF pairs per flash (≥1)

Ports:
- clk  in  1  system clock
- resetN  in  1  reset; synchronous, active-low
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- startOfFrame  in  1  one-cycle pulse at frame start
- flashTrig  in  1  one-cycle pulse that starts or restarts a flash
- BG_RGB  out  8  background colour, registered
- boardersDrawReq  out  1  high when the registered pixel is a border pixel
- flashActive  out  1  high whenever the FSM is not in IDLE

## Operation
Region classification is combinational and then registered. Define XL=BORDER_OFFSET, XR=FRAME_W-1-BORDER_OFFSET, YT=BORDER_OFFSET, YB=FRAME_H-1-BORDER_OFFSET, T=BORDER_THICK. Regions are tested in this priority order:
- **Blank:** pixelX≥FRAME_W or pixelY≥FRAME_H → colour 8'h00, req 0.
- **Outside:** pixelX<XL, pixelX>XR, pixelY<YT or pixelY>YB → OUTSIDE_COLOR, req 0.
- **Border:** inside the XL..XR × YT..YB box and (pixelX≤XL+T-1 or pixelX≥XR-T+1 or pixelY≤YT+T-1 or pixelY≥YB-T+1) → current border colour, req 1.
- **Floor:** all remaining pixels.
  - Compute tx=(pixelX-(XL+T))>>TILE_LOG2 and ty=(pixelY-(YT+T))>>TILE_LOG2, both 11-bit unsigned.
  - tx[0]^ty[0]=0 → FLOOR_A, else FLOOR_B. req 0.

Flash FSM states are IDLE, FLASH_ON and FLASH_OFF. It uses a frame counter (width $clog2(FLASH_PERIOD)+1) and a blink counter (width $clog2(FLASH_BLINKS)+1).
- **IDLE:** border = BORDER_COLOR. flashTrig → FLASH_ON, frame counter=0, blink counter=0.
- **FLASH_ON:** border = FLASH_COLOR. On startOfFrame, increment the frame counter. When startOfFrame arrives with the counter at FLASH_PERIOD-1: counter=0, blink counter +1, go to FLASH_OFF.
- **FLASH_OFF:** border = BORDER_COLOR. Frame counting is identical to FLASH_ON. When the period ends: if blink counter==FLASH_BLINKS go to IDLE, else go to FLASH_ON.
- **flashTrig in any state:** go to FLASH_ON with both counters cleared.
- **flashTrig and startOfFrame in the same cycle:** flashTrig wins and that frame pulse is not counted.
- **Total flash duration:** 2·FLASH_PERIOD·FLASH_BLINKS startOfFrame pulses after the trigger.

## Timing
- **Reset** (resetN low at a clk edge): BG_RGB=8'h00, boardersDrawReq=0, flashActive=0, state=IDLE, counters=0. Reset mid-flash aborts the flash immediately.
- **Latency:** BG_RGB and boardersDrawReq reflect the pixelX/pixelY sampled at the previous edge, giving exactly 1 cycle of latency. Every clk edge updates them; there is no enable.
- **Border colour source:** the border colour used at edge n is the FSM state held before edge n. A state change therefore shows on BG_RGB from the second edge after the triggering pulse.
- **flashActive:** registered; it rises on the edge that samples flashTrig and falls on the edge that enters IDLE.
- **Width rule:** all comparisons are 11-bit unsigned. The floor subtraction is only evaluated when the result is non-negative, which is guaranteed by the region priority.

## Test plan
- **Reset:** hold resetN=0 for 3 cycles with pixel (100,100) → BG_RGB=8'h00, req=0, flashActive=0. Release → one cycle later BG_RGB=8'h49.
- **Border edges** (defaults): pixels (30,100), (31,100), (608,100), (609,200), (100,448), (100,449) → 8'hFC, req=1. Pixels (29,100) and (610,100) → 8'hFF, req=0.
- **Checkerboard:**
  - (32,32) → 8'h49; (63,32) → 8'h49; (64,32) → 8'h6D.
  - (64,64) → 8'h49; (32,64) → 8'h6D.
- **Blank region:** (700,10) and (10,500) → 8'h00, req=0.
- **Flash sequence:** pulse flashTrig, then issue 24 startOfFrame pulses while sampling the border at (30,30).
  - Border reads 8'hE0 for frames 0–3, 8'hFC for frames 4–7, and alternates in this pattern.
  - flashActive drops after the 24th pulse, and the border stays 8'hFC.
- **Restart and collision:**
  - flashTrig at frame 10 of a flash, in the same cycle as startOfFrame → FLASH_ON with counters cleared; a further 24 pulses are needed to reach IDLE.
  - Reset at frame 5 → IDLE, flashActive=0.
